// File: rtl/utopia_tx_sched.sv
// Round-robin scheduler sharing one UTOPIA Tx port among NumPorts cell sources.
// Grants one requester, pops exactly CellBytes bytes from it, then idles one GAP cycle.
module utopia_tx_sched #(
    parameter int NumPorts  = 4,
    parameter int IfWidth   = 8,
    parameter int CellBytes = 53
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NumPorts-1:0]         port_en,
    input  logic [NumPorts-1:0]         req,
    input  logic [NumPorts*IfWidth-1:0] src_data,
    output logic [NumPorts-1:0]         gnt,
    output logic [NumPorts-1:0]         rd,
    output logic [IfWidth-1:0]          tx_data,
    output logic                        tx_soc,
    output logic                        tx_en,
    input  logic                        tx_clav,
    output logic                        cell_done,
    output logic                        busy
);
    localparam int IdxW = $clog2(NumPorts);
    localparam int CntW = $clog2(CellBytes);
    localparam logic [CntW-1:0] LastCnt = CntW'(CellBytes - 1);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t              r_state;
    logic [NumPorts-1:0] r_gnt;
    logic [CntW-1:0]     r_cnt;
    logic [IdxW-1:0]     r_last;
    logic [IfWidth-1:0]  r_tx_data;
    logic                r_tx_soc;
    logic                r_tx_en;
    logic                r_cell_done;

    logic [NumPorts-1:0] w_elig;
    logic                w_found;
    logic [IdxW-1:0]     w_pick;
    logic [NumPorts-1:0] w_pick_oh;
    logic [IfWidth-1:0]  w_slice [NumPorts];
    logic [IfWidth-1:0]  w_mux;

    assign w_elig = req & port_en;

    // Search upward from last+1 so the most recently served port has lowest priority.
    always_comb begin
        int              v_int;
        logic [IdxW-1:0] v_idx;
        w_found = 1'b0;
        w_pick  = '0;
        v_int   = 0;
        v_idx   = '0;
        for (int k = 1; k <= NumPorts; k++) begin
            v_int = int'(r_last) + k;
            if (v_int >= NumPorts) begin
                v_int = v_int - NumPorts;
            end
            v_idx = v_int[IdxW-1:0];
            if (!w_found && w_elig[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    assign w_pick_oh = NumPorts'(1) << w_pick;

    // Data mux is an AND-OR over the registered one-hot grant.
    generate
        for (genvar gi = 0; gi < NumPorts; gi++) begin : g_slice
            assign w_slice[gi] = src_data[gi*IfWidth +: IfWidth] & {IfWidth{r_gnt[gi]}};
        end
    endgenerate

    always_comb begin
        w_mux = '0;
        for (int i = 0; i < NumPorts; i++) begin
            w_mux = w_mux | w_slice[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_cnt       <= '0;
            r_last      <= IdxW'(NumPorts - 1);
            r_tx_data   <= '0;
            r_tx_soc    <= 1'b0;
            r_tx_en     <= 1'b0;
            r_cell_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx_en     <= 1'b0;
                    r_tx_soc    <= 1'b0;
                    r_cell_done <= 1'b0;
                    if (tx_clav && w_found) begin
                        r_gnt   <= w_pick_oh;
                        r_cnt   <= '0;
                        r_last  <= w_pick;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    r_tx_data   <= w_mux;
                    r_tx_en     <= 1'b1;
                    r_tx_soc    <= (r_cnt == '0);
                    r_cnt       <= r_cnt + 1'b1;
                    r_cell_done <= 1'b0;
                    if (r_cnt == LastCnt) begin
                        r_cell_done <= 1'b1;
                        r_gnt       <= '0;
                        r_state     <= GAP;
                    end
                end
                GAP: begin
                    r_tx_en     <= 1'b0;
                    r_tx_soc    <= 1'b0;
                    r_cell_done <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rd        = r_gnt & {NumPorts{r_state == XFER}};
    assign tx_data   = r_tx_data;
    assign tx_soc    = r_tx_soc;
    assign tx_en     = r_tx_en;
    assign cell_done = r_cell_done;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_utopia_tx_sched.sv
// Bench for utopia_tx_sched: counter-pattern sources, cell scoreboard, one task per scenario.
module tb_utopia_tx_sched;
    typedef struct packed {
        logic [3:0] port;
        logic [7:0] first;
        logic [7:0] nbytes;
        logic       contig;
    } cell_t;

    logic        clk = 1'b0;
    logic        rst, tx_clav, src_flush;
    logic [3:0]  req, port_en;
    logic [31:0] src_data;
    logic [3:0]  gnt, rd;
    logic [7:0]  tx_data;
    logic        tx_soc, tx_en, cell_done, busy;

    logic [7:0]  base [4] = '{8'h10, 8'h50, 8'h00, 8'hA0};
    int          src_cnt [4] = '{0, 0, 0, 0};
    int          exp_cells [4] = '{0, 0, 0, 0};
    int          cyc = 0;
    int          n_chk = 0, n_pass = 0;

    cell_t       exp_q[$];
    cell_t       obs_q[$];
    int          obs_t[$];
    cell_t       cur;
    int          cur_t;
    bit          in_cell = 1'b0;
    logic [7:0]  prev;
    int          n_rd = 0, n_done = 0, stray = 0, spurious = 0;

    utopia_tx_sched #(.NumPorts(4), .IfWidth(8), .CellBytes(53)) dut (
        .clk(clk), .rst(rst), .port_en(port_en), .req(req), .src_data(src_data),
        .gnt(gnt), .rd(rd), .tx_data(tx_data), .tx_soc(tx_soc), .tx_en(tx_en),
        .tx_clav(tx_clav), .cell_done(cell_done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // First-word-fall-through sources: each port emits base+count, advancing on rd.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (src_flush) src_cnt[i] <= 0;
            else if (rd[i]) src_cnt[i] <= src_cnt[i] + 1;
        end
    end

    always_comb begin
        src_data = '0;
        for (int i = 0; i < 4; i++) src_data[i*8 +: 8] = base[i] + src_cnt[i][7:0];
    end

    function automatic int oh_idx(input logic [3:0] v);
        if ($countones(v) != 1) return 15;
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 15;
    endfunction

    // Monitor: assembles observed cells from the Tx bus.
    always @(negedge clk) begin
        if (rst) begin
            in_cell = 1'b0;
        end else begin
            if (|rd) n_rd++;
            if (tx_en) begin
                if (tx_soc) begin
                    cur.port = 4'(oh_idx(gnt));
                    cur.first = tx_data;
                    cur.nbytes = 8'd1;
                    cur.contig = 1'b1;
                    cur_t = cyc;
                    in_cell = 1'b1;
                end else if (in_cell) begin
                    cur.nbytes = cur.nbytes + 8'd1;
                    if (tx_data !== prev + 8'd1) cur.contig = 1'b0;
                end else begin
                    stray++;
                end
                prev = tx_data;
            end
            if (cell_done) begin
                if (in_cell && tx_en) begin
                    obs_q.push_back(cur);
                    obs_t.push_back(cur_t);
                    n_done++;
                end else begin
                    spurious++;
                end
                in_cell = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int p);
        cell_t e;
        e.port   = 4'(p);
        e.first  = base[p] + 8'(53 * exp_cells[p]);
        e.nbytes = 8'd53;
        e.contig = 1'b1;
        exp_q.push_back(e);
        exp_cells[p]++;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        src_flush = 1'b1;
        step();
        step();
        rst = 1'b0;
        src_flush = 1'b0;
        for (int i = 0; i < 4; i++) exp_cells[i] = 0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        while (n_done < target && budget > 0) begin
            step();
            budget--;
        end
        ok = (n_done >= target);
    endtask

    task automatic test_reset();
        rst = 1'b1; src_flush = 1'b1; req = 4'h0; port_en = 4'hF; tx_clav = 1'b0;
        step();
        step();
        n_chk++; if (gnt !== 4'h0) $display("FAIL rst_gnt: got %b expected 0000", gnt); else n_pass++;
        n_chk++; if (rd !== 4'h0) $display("FAIL rst_rd: got %b expected 0000", rd); else n_pass++;
        n_chk++; if (tx_data !== 8'h00) $display("FAIL rst_data: got %h expected 00", tx_data); else n_pass++;
        n_chk++; if ({tx_soc, tx_en, cell_done, busy} !== 4'b0000)
            $display("FAIL rst_ctl: got soc/en/done/busy=%b expected 0000", {tx_soc, tx_en, cell_done, busy});
        else n_pass++;
        rst = 1'b0; src_flush = 1'b0;
    endtask

    task automatic test_single();
        int t0; int d0; bit ok;
        d0 = n_done;
        push_exp(2);
        req = 4'b0100; port_en = 4'hF; tx_clav = 1'b1;
        step();
        t0 = cyc;
        n_chk++; if (gnt !== 4'b0100) $display("FAIL single_gnt: got %b expected 0100", gnt); else n_pass++;
        n_chk++; if (rd !== 4'b0100) $display("FAIL single_rd: got %b expected 0100", rd); else n_pass++;
        wait_done(d0 + 1, 70, ok);
        req = 4'h0;
        n_chk++; if (!ok) $display("FAIL single_timeout: got %0d cells expected %0d", n_done - d0, 1); else n_pass++;
        n_chk++; if (cyc - t0 !== 53) $display("FAIL single_done_lat: got %0d expected 53", cyc - t0); else n_pass++;
        step();
        n_chk++; if (tx_en !== 1'b0) $display("FAIL single_gap_en: got %b expected 0", tx_en); else n_pass++;
        step();
        n_chk++; if (busy !== 1'b0 || gnt !== 4'h0) $display("FAIL single_idle: got busy=%b gnt=%b expected 0/0000", busy, gnt); else n_pass++;
        while (exp_q.size() > 0) begin
            cell_t e; cell_t o;
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q.size() == 0) begin
                $display("FAIL single_cell: got no cell expected port=%0d", e.port);
            end else begin
                o = obs_q.pop_front(); void'(obs_t.pop_front());
                if (o !== e) $display("FAIL single_cell: got port=%0d first=%h n=%0d contig=%0b expected port=%0d first=%h n=%0d contig=%0b",
                                      o.port, o.first, o.nbytes, o.contig, e.port, e.first, e.nbytes, e.contig);
                else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        int d0; bit ok; int times [$];
        pulse_rst();
        d0 = n_done;
        for (int k = 0; k < 8; k++) push_exp(k % 4);
        req = 4'hF; port_en = 4'hF; tx_clav = 1'b1;
        wait_done(d0 + 8, 8 * 55 + 20, ok);
        req = 4'h0;
        n_chk++; if (!ok) $display("FAIL rr_timeout: got %0d cells expected 8", n_done - d0); else n_pass++;
        step();
        step();
        n_chk++; if (busy !== 1'b0) $display("FAIL rr_idle: got busy=%b expected 0", busy); else n_pass++;
        while (exp_q.size() > 0) begin
            cell_t e; cell_t o;
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q.size() == 0) begin
                $display("FAIL rr_cell: got no cell expected port=%0d", e.port);
            end else begin
                o = obs_q.pop_front(); times.push_back(obs_t.pop_front());
                if (o !== e) $display("FAIL rr_cell: got port=%0d first=%h n=%0d contig=%0b expected port=%0d first=%h n=%0d contig=%0b",
                                      o.port, o.first, o.nbytes, o.contig, e.port, e.first, e.nbytes, e.contig);
                else n_pass++;
            end
        end
        for (int k = 1; k < times.size(); k++) begin
            n_chk++;
            if (times[k] - times[k-1] !== 55) $display("FAIL rr_spacing%0d: got %0d expected 55", k, times[k] - times[k-1]);
            else n_pass++;
        end
    endtask

    task automatic test_clav();
        int d0; bit ok; bit bad;
        d0 = n_done;
        bad = 1'b0;
        req = 4'b0001; port_en = 4'hF; tx_clav = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (gnt !== 4'h0 || tx_en !== 1'b0) bad = 1'b1;
        end
        n_chk++; if (bad) $display("FAIL clav_hold: got gnt/tx_en activity expected none while clav=0"); else n_pass++;
        push_exp(0);
        tx_clav = 1'b1;
        step();
        n_chk++; if (gnt !== 4'b0001) $display("FAIL clav_gnt: got %b expected 0001", gnt); else n_pass++;
        repeat (11) step();
        tx_clav = 1'b0;
        wait_done(d0 + 1, 70, ok);
        n_chk++; if (!ok) $display("FAIL clav_timeout: got %0d cells expected 1", n_done - d0); else n_pass++;
        repeat (5) step();
        n_chk++; if (busy !== 1'b0 || gnt !== 4'h0) $display("FAIL clav_idle: got busy=%b gnt=%b expected 0/0000", busy, gnt); else n_pass++;
        req = 4'h0; tx_clav = 1'b1;
        while (exp_q.size() > 0) begin
            cell_t e; cell_t o;
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q.size() == 0) begin
                $display("FAIL clav_cell: got no cell expected port=%0d", e.port);
            end else begin
                o = obs_q.pop_front(); void'(obs_t.pop_front());
                if (o !== e) $display("FAIL clav_cell: got port=%0d first=%h n=%0d contig=%0b expected port=%0d first=%h n=%0d contig=%0b",
                                      o.port, o.first, o.nbytes, o.contig, e.port, e.first, e.nbytes, e.contig);
                else n_pass++;
            end
        end
    endtask

    task automatic test_mid_reset();
        int d0; bit ok;
        req = 4'b0010; port_en = 4'hF; tx_clav = 1'b1;
        step();
        n_chk++; if (gnt !== 4'b0010) $display("FAIL mrst_gnt1: got %b expected 0010", gnt); else n_pass++;
        repeat (31) step();
        n_chk++; if (tx_data !== base[1] + 8'(53 * exp_cells[1] + 30))
            $display("FAIL mrst_byte30: got %h expected %h", tx_data, base[1] + 8'(53 * exp_cells[1] + 30));
        else n_pass++;
        rst = 1'b1; src_flush = 1'b1;
        step();
        n_chk++; if ({gnt, rd} !== 8'h00) $display("FAIL mrst_gnt_rd: got gnt=%b rd=%b expected 0", gnt, rd); else n_pass++;
        n_chk++; if (tx_data !== 8'h00) $display("FAIL mrst_data: got %h expected 00", tx_data); else n_pass++;
        n_chk++; if ({tx_soc, tx_en, cell_done, busy} !== 4'b0000)
            $display("FAIL mrst_ctl: got soc/en/done/busy=%b expected 0000", {tx_soc, tx_en, cell_done, busy});
        else n_pass++;
        rst = 1'b0; src_flush = 1'b0;
        for (int i = 0; i < 4; i++) exp_cells[i] = 0;
        d0 = n_done;
        push_exp(0);
        req = 4'b0011;
        step();
        n_chk++; if (gnt !== 4'b0001) $display("FAIL mrst_gnt2: got %b expected 0001", gnt); else n_pass++;
        wait_done(d0 + 1, 70, ok);
        req = 4'h0;
        n_chk++; if (!ok) $display("FAIL mrst_timeout: got %0d cells expected 1", n_done - d0); else n_pass++;
        step();
        step();
        while (exp_q.size() > 0) begin
            cell_t e; cell_t o;
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q.size() == 0) begin
                $display("FAIL mrst_cell: got no cell expected port=%0d", e.port);
            end else begin
                o = obs_q.pop_front(); void'(obs_t.pop_front());
                if (o !== e) $display("FAIL mrst_cell: got port=%0d first=%h n=%0d contig=%0b expected port=%0d first=%h n=%0d contig=%0b",
                                      o.port, o.first, o.nbytes, o.contig, e.port, e.first, e.nbytes, e.contig);
                else n_pass++;
            end
        end
    endtask

    task automatic test_port_en();
        int d0; bit ok;
        d0 = n_done;
        push_exp(1); push_exp(3); push_exp(1); push_exp(3);
        req = 4'hF; port_en = 4'b1010; tx_clav = 1'b1;
        wait_done(d0 + 3, 3 * 55 + 20, ok);
        n_chk++; if (!ok) $display("FAIL en_timeout3: got %0d cells expected 3", n_done - d0); else n_pass++;
        repeat (10) step();
        port_en = 4'h0;
        wait_done(d0 + 4, 70, ok);
        n_chk++; if (!ok) $display("FAIL en_timeout4: got %0d cells expected 4", n_done - d0); else n_pass++;
        repeat (5) step();
        n_chk++; if (busy !== 1'b0) $display("FAIL en_idle: got busy=%b expected 0", busy); else n_pass++;
        repeat (60) step();
        n_chk++; if (n_done - d0 !== 4 || busy !== 1'b0)
            $display("FAIL en_stay_idle: got cells=%0d busy=%b expected 4/0", n_done - d0, busy);
        else n_pass++;
        req = 4'h0; port_en = 4'hF;
        while (exp_q.size() > 0) begin
            cell_t e; cell_t o;
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q.size() == 0) begin
                $display("FAIL en_cell: got no cell expected port=%0d", e.port);
            end else begin
                o = obs_q.pop_front(); void'(obs_t.pop_front());
                if (o !== e) $display("FAIL en_cell: got port=%0d first=%h n=%0d contig=%0b expected port=%0d first=%h n=%0d contig=%0b",
                                      o.port, o.first, o.nbytes, o.contig, e.port, e.first, e.nbytes, e.contig);
                else n_pass++;
            end
        end
    endtask

    task automatic test_req_drop();
        int d0; int r0; bit ok;
        d0 = n_done;
        r0 = n_rd;
        push_exp(1); push_exp(2);
        req = 4'b0110; port_en = 4'hF; tx_clav = 1'b1;
        step();
        n_chk++; if (gnt !== 4'b0010) $display("FAIL drop_gnt: got %b expected 0010", gnt); else n_pass++;
        repeat (6) step();
        req = 4'b0100;
        wait_done(d0 + 1, 70, ok);
        n_chk++; if (!ok) $display("FAIL drop_timeout1: got %0d cells expected 1", n_done - d0); else n_pass++;
        n_chk++; if (n_rd - r0 !== 53) $display("FAIL drop_rd_pulses: got %0d expected 53", n_rd - r0); else n_pass++;
        wait_done(d0 + 2, 70, ok);
        req = 4'h0;
        n_chk++; if (!ok) $display("FAIL drop_timeout2: got %0d cells expected 2", n_done - d0); else n_pass++;
        repeat (3) step();
        while (exp_q.size() > 0) begin
            cell_t e; cell_t o;
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q.size() == 0) begin
                $display("FAIL drop_cell: got no cell expected port=%0d", e.port);
            end else begin
                o = obs_q.pop_front(); void'(obs_t.pop_front());
                if (o !== e) $display("FAIL drop_cell: got port=%0d first=%h n=%0d contig=%0b expected port=%0d first=%h n=%0d contig=%0b",
                                      o.port, o.first, o.nbytes, o.contig, e.port, e.first, e.nbytes, e.contig);
                else n_pass++;
            end
        end
        n_chk++; if (obs_q.size() !== 0) $display("FAIL extra_cells: got %0d unexpected cells expected 0", obs_q.size()); else n_pass++;
        n_chk++; if (stray !== 0 || spurious !== 0)
            $display("FAIL bus_protocol: got stray_beats=%0d spurious_done=%0d expected 0/0", stray, spurious);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_clav();
        test_mid_reset();
        test_port_en();
        test_req_drop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/utopia_tx_sched.md
# utopia_tx_sched

Round-robin scheduler that shares one UTOPIA transmit port among `NumPorts` cell sources in the ATM switch. It grants one requester at a time and pops exactly one 53-byte cell from it. It drives the cell onto the UTOPIA Tx signals (`data`/`soc`/`en`), admitting a new cell only when the PHY reports `clav`. It sits between the per-port output queues and the `Utopia.TopTransmit` side of the switch.

## Interface

Parameters:
- `NumPorts`, 4, number of requesters (2..16).
- `IfWidth`, 8, UTOPIA data width.
- `CellBytes`, 53, transfers per cell.

Ports:
- `clk` input 1: single clock, all logic on posedge.
- `rst` input 1: reset, synchronous and active-high.
- `port_en` input NumPorts: per-requester enable mask; a masked requester is never granted.
- `req` input NumPorts: requester i holds a complete cell; held high for the whole cell once granted.
- `src_data` input NumPorts*IfWidth: flattened; slice i is requester i's current byte (first-word-fall-through).
- `gnt` output NumPorts: one-hot grant, registered, held for the whole cell.
- `rd` output NumPorts: pop strobe, `rd[i] = gnt[i] & (state==XFER)`; requester i advances its byte on each edge with `rd[i]=1`.
- `tx_data` output IfWidth: UTOPIA Tx data, registered.
- `tx_soc` output 1: start of cell; high with byte 0 only.
- `tx_en` output 1: active-high; `tx_data` valid this cycle.
- `tx_clav` input 1: PHY can accept one cell.
- `cell_done` output 1: one-cycle pulse, concurrent with last byte on `tx_en`.
- `busy` output 1: state != IDLE.

## Operation

FSM states: IDLE, XFER, GAP.

**IDLE**
- Eligible set = `req & port_en`.
- On an edge with `tx_clav=1` and a non-empty eligible set:
  - Pick the first eligible index searching upward from `(last+1) mod NumPorts`.
  - `gnt` <= one-hot of that index; `cnt` <= 0; `last` <= index; go to XFER.
- Otherwise stay in IDLE; `tx_en` <= 0.

**XFER** (`rd` of the granted port is high)
- Each edge:
  - `tx_data` <= granted slice of `src_data`.
  - `tx_en` <= 1.
  - `tx_soc` <= (`cnt`==0).
  - `cnt` <= `cnt`+1.
- On the edge with `cnt==CellBytes-1`:
  - `cell_done` <= 1.
  - `gnt` <= 0.
  - Go to GAP.

**GAP**
- `tx_en`, `tx_soc`, `cell_done` <= 0; go to IDLE.
- `tx_data` holds its last value.

Counter and mux rules:
- `cnt` width is `$clog2(CellBytes)`; it never wraps inside a cell.
- The mux select derives from registered `gnt` only.

Boundary rules:
- `tx_clav` is sampled only in IDLE. A `clav` drop during XFER does not stall or abort the cell.
- `req`/`port_en` changes during XFER or GAP are ignored until the next IDLE evaluation. Deasserting `req` mid-cell is a requester protocol violation; the block still pops `CellBytes` bytes.
- Simultaneous requests: the round-robin order from `last+1` is the sole tie-break.
- Only one requester eligible: it is re-granted back-to-back; no starvation gap is imposed beyond GAP+IDLE.
- `port_en` all zero: the block remains in IDLE indefinitely.

Reset, including mid-cell:
- Next edge: state=IDLE, `cnt`=0, `last`=NumPorts-1 (port 0 has first priority).
- All outputs 0: `gnt`, `rd`, `tx_data`, `tx_soc`, `tx_en`, `cell_done`, `busy`.
- The partial cell is abandoned and not resumed.

## Timing

- Edge E0: IDLE samples `tx_clav=1` and request → `gnt` valid after E0; `rd` high after E0 through E53 (53 cycles).
- Edges E1..E53 register bytes 0..52; `tx_en` high for the 53 cycles after E1..E53.
- `tx_soc` is high only in the cycle after E1; `cell_done` is high only in the cycle after E53.
- After E53: `gnt`=0 and `rd`=0.
- E54 (GAP): `tx_en` <= 0. E55: first IDLE evaluation for the next cell.
- Minimum cell period: 55 cycles. Grant latency from request: 1 edge.

## Test plan

1. After reset, `req=4'b0100`, `port_en=4'hF`, `tx_clav=1`, `src_data` slice 2 = byte counter 0x00..0x34 → `gnt=4'b0100` after 1 edge; 53 `tx_en` beats carrying 0x00..0x34; `tx_soc` on 0x00 only; `cell_done` on 0x34; `busy` low at E55.
2. `req=4'hF` held, `tx_clav=1`, 8 cells → grant order 0,1,2,3,0,1,2,3; 55-cycle spacing between `tx_soc` pulses.
3. `req=4'b0001`, `tx_clav=0` for 20 cycles, then 1 → no `gnt`/`tx_en` while `clav` is low; `gnt` one edge after `clav` rises. Separately, dropping `clav` at byte 10 → all 53 bytes still sent.
4. `rst` pulsed at byte 30 of a port-1 cell → next cycle all outputs 0. With `req=4'b0011`, the next grant is port 0, and the new cell restarts at byte 0 with `tx_soc`.
5. `req=4'hF`, `port_en=4'b1010` → grants alternate 1,3,1,3. Setting `port_en=0` mid-cell completes the current cell, then the block stays IDLE with `busy=0`.
6. `req` of the granted port dropped at byte 5 → exactly 53 `rd` pulses and `cell_done` still asserted; next grant follows round-robin order.
